// File: rtl/dma_io_peripheral.sv
// Peripheral-side 8237A DMA channel responder: raises DREQ, follows DACK and the nIOR/nIOW strobes,
// and moves bytes between the ISA-style data bus and local TX/RX FIFOs.
module dma_io_peripheral #(
  parameter int FIFO_DEPTH = 8,
  parameter bit DEMAND     = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       req_start,
  input  logic       dir,
  output logic       DREQ,
  input  logic       nDACK,
  input  logic       nIOR,
  input  logic       nIOW,
  input  logic       nEOP,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  output logic [2:0] dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] L_FULL = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACK  = 3'd2,
    S_WAIT = 3'd3,
    S_TERM = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_dir;
  logic          r_dreq;
  logic          r_done;
  logic          r_busy;
  logic          r_ior_q;
  logic          r_iow_q;
  logic [7:0]    r_din;
  logic [1:0]    r_err;
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_tx_wr;
  logic [PW-1:0] r_tx_rd;
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rx_wr;
  logic [PW-1:0] r_rx_rd;

  state_t        w_state_nxt;
  logic          w_dreq_nxt;
  logic          w_dack;
  logic          w_eop;
  logic          w_ior_rise;
  logic          w_iow_rise;
  logic          w_strobe;
  logic [PW-1:0] w_tx_count;
  logic [PW-1:0] w_rx_count;
  logic [PW-1:0] w_tx_count_nxt;
  logic [PW-1:0] w_rx_count_nxt;
  logic          w_tx_empty;
  logic          w_tx_full;
  logic          w_rx_empty;
  logic          w_rx_full;
  logic          w_tx_push;
  logic          w_tx_pop;
  logic          w_tx_unf;
  logic          w_rx_push;
  logic          w_rx_pop;
  logic          w_rx_ovf;
  logic          w_exhausted_nxt;

  // Bus handshake: a strobe counts only in ACK with DACK low, and completes on its rising edge
  // (registered previous sample low, current sample high). Local sides are valid/ready: a byte
  // moves on any cycle where valid and ready are both high.
  assign w_dack     = !nDACK;
  assign w_ior_rise = (r_state == S_ACK) && w_dack && !r_dir && !r_ior_q && nIOR;
  assign w_iow_rise = (r_state == S_ACK) && w_dack &&  r_dir && !r_iow_q && nIOW;
  assign w_strobe   = w_ior_rise || w_iow_rise;
  assign w_eop      = w_dack && !nEOP &&
                      ((r_state == S_REQ) || (r_state == S_ACK) || (r_state == S_WAIT));

  assign w_tx_count = r_tx_wr - r_tx_rd;
  assign w_rx_count = r_rx_wr - r_rx_rd;
  assign w_tx_empty = (w_tx_count == '0);
  assign w_tx_full  = (w_tx_count == L_FULL);
  assign w_rx_empty = (w_rx_count == '0);
  assign w_rx_full  = (w_rx_count == L_FULL);

  assign w_tx_push = tx_valid && !w_tx_full;
  assign w_tx_pop  = w_ior_rise && !w_tx_empty;
  assign w_tx_unf  = w_ior_rise && w_tx_empty;
  assign w_rx_pop  = !w_rx_empty && rx_ready;
  // A full RX still accepts a byte when the consumer frees a slot in the same cycle.
  assign w_rx_push = w_iow_rise && (!w_rx_full || w_rx_pop);
  assign w_rx_ovf  = w_iow_rise && w_rx_full && !w_rx_pop;

  assign w_tx_count_nxt = w_tx_count + PW'(w_tx_push) - PW'(w_tx_pop);
  assign w_rx_count_nxt = w_rx_count + PW'(w_rx_push) - PW'(w_rx_pop);
  assign w_exhausted_nxt = r_dir ? (w_rx_count_nxt == L_FULL) : (w_tx_count_nxt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_start) w_state_nxt = S_REQ;
      S_REQ:  if (w_dack) w_state_nxt = S_ACK;
      S_ACK: begin
        if (!DEMAND && w_strobe) w_state_nxt = S_WAIT;
        else if (!w_dack)        w_state_nxt = S_REQ;
      end
      S_WAIT: if (!w_dack) w_state_nxt = S_REQ;
      S_TERM: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_eop) w_state_nxt = S_TERM;
  end

  always_comb begin
    w_dreq_nxt = 1'b0;
    case (w_state_nxt)
      S_REQ:   w_dreq_nxt = 1'b1;
      S_ACK:   w_dreq_nxt = DEMAND && !w_exhausted_nxt;
      default: w_dreq_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_dreq  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ior_q <= 1'b1;
      r_iow_q <= 1'b1;
      r_din   <= 8'h00;
      r_err   <= 2'b00;
      r_tx_wr <= '0;
      r_tx_rd <= '0;
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dreq  <= w_dreq_nxt;
      r_done  <= (w_state_nxt == S_TERM);
      r_busy  <= (w_state_nxt != S_IDLE);
      if ((r_state == S_IDLE) && req_start) r_dir <= dir;
      r_ior_q <= nIOR;
      r_iow_q <= nIOW;
      if (!nIOW) r_din <= data_in;
      r_err   <= r_err | {w_rx_ovf, w_tx_unf};
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
    end
  end

  // Storage arrays need no reset; the pointers define what is valid.
  always_ff @(posedge Clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= r_din;
  end

  assign DREQ      = r_dreq;
  assign done      = r_done;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dbg_state = r_state;
  assign data_out  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd[AW-1:0]];
  assign data_oe   = (r_state == S_ACK) && !r_dir && w_dack && !nIOR;
  assign tx_ready  = !w_tx_full;
  assign rx_valid  = !w_rx_empty;
  assign rx_data   = r_rx_mem[r_rx_rd[AW-1:0]];

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Directed bench for dma_io_peripheral: one single-mode and one demand-mode instance share stimulus;
// each step checks the instance whose mode it exercises.
module tb_dma_io_peripheral;

  logic       Clock = 1'b0;
  logic       Reset, req_start, dir, nDACK, nIOR, nIOW, nEOP, tx_valid, rx_ready;
  logic [7:0] data_in, tx_data;

  logic       s_dreq, s_oe, s_tx_ready, s_rx_valid, s_busy, s_done;
  logic [7:0] s_dout, s_rx_data;
  logic [1:0] s_err;
  logic [2:0] s_dbg;
  logic       d_dreq, d_oe, d_tx_ready, d_rx_valid, d_busy, d_done;
  logic [7:0] d_dout, d_rx_data;
  logic [1:0] d_err;
  logic [2:0] d_dbg;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_bytes [3];

  dma_io_peripheral #(.FIFO_DEPTH(8), .DEMAND(1'b0)) u_sgl (
    .Clock(Clock), .Reset(Reset), .req_start(req_start), .dir(dir), .DREQ(s_dreq),
    .nDACK(nDACK), .nIOR(nIOR), .nIOW(nIOW), .nEOP(nEOP), .data_out(s_dout), .data_oe(s_oe),
    .data_in(data_in), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(s_tx_ready),
    .rx_valid(s_rx_valid), .rx_data(s_rx_data), .rx_ready(rx_ready), .busy(s_busy),
    .done(s_done), .err(s_err), .dbg_state(s_dbg)
  );

  dma_io_peripheral #(.FIFO_DEPTH(8), .DEMAND(1'b1)) u_dmd (
    .Clock(Clock), .Reset(Reset), .req_start(req_start), .dir(dir), .DREQ(d_dreq),
    .nDACK(nDACK), .nIOR(nIOR), .nIOW(nIOW), .nEOP(nEOP), .data_out(d_dout), .data_oe(d_oe),
    .data_in(data_in), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(d_tx_ready),
    .rx_valid(d_rx_valid), .rx_data(d_rx_data), .rx_ready(rx_ready), .busy(d_busy),
    .done(d_done), .err(d_err), .dbg_state(d_dbg)
  );

  // Clock and watchdog
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge Clock);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc();
    cyc();
    Reset = 1'b0;
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    cyc();
    tx_valid = 1'b0;
  endtask

  task automatic iow_byte(input logic [7:0] b);
    data_in = b;
    nIOW    = 1'b0;
    cyc();
    nIOW    = 1'b1;
    cyc();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; req_start = 1'b0; dir = 1'b0; nDACK = 1'b1; nIOR = 1'b1; nIOW = 1'b1;
    nEOP = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; data_in = 8'h00; rx_ready = 1'b0;
    tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h5A; tx_bytes[2] = 8'h3C;
    do_reset();

    // Reset in the middle of a started service
    tx_push(8'h11);
    tx_push(8'h22);
    req_start = 1'b1; dir = 1'b0;
    cyc();
    req_start = 1'b0;
    chk("pre_rst_dreq", s_dreq, 8'h01);
    chk("pre_rst_busy", s_busy, 8'h01);
    chk("pre_rst_head", s_dout, 8'h11);
    Reset = 1'b1;
    cyc();
    chk("rst_dreq_drop", s_dreq, 8'h00);
    cyc();
    Reset = 1'b0;
    chk("rst_dout", s_dout, 8'h00);
    chk("rst_oe", s_oe, 8'h00);
    chk("rst_tx_ready", s_tx_ready, 8'h01);
    chk("rst_rx_valid", s_rx_valid, 8'h00);
    chk("rst_busy", s_busy, 8'h00);
    chk("rst_done", s_done, 8'h00);
    chk("rst_err", s_err, 8'h00);
    chk("rst_state", s_dbg, 8'h00);
    chk("rst_d_dreq", d_dreq, 8'h00);
    chk("rst_d_rx_valid", d_rx_valid, 8'h00);

    // Single mode, device->memory: three bytes, one per DACK cycle
    tx_push(8'hA5);
    tx_push(8'h5A);
    tx_push(8'h3C);
    req_start = 1'b1; dir = 1'b0;
    cyc();
    req_start = 1'b0;
    chk("sgl_dreq_latency", s_dreq, 8'h01);
    for (int i = 0; i < 3; i++) begin
      nDACK = 1'b0;
      cyc();
      chk("sgl_dreq_ack", s_dreq, 8'h00);
      nIOR = 1'b0;
      #1;
      chk("sgl_oe", s_oe, 8'h01);
      chk("sgl_data", s_dout, tx_bytes[i]);
      cyc();
      nIOR = 1'b1;
      cyc();
      chk("sgl_oe_off", s_oe, 8'h00);
      chk("sgl_wait", s_dbg, 8'h03);
      if (i < 2) begin
        nDACK = 1'b1;
        cyc();
        chk("sgl_dreq_again", s_dreq, 8'h01);
      end
    end
    chk("sgl_err", s_err, 8'h00);

    // Termination after the third byte
    nEOP = 1'b0;
    cyc();
    chk("term_dreq", s_dreq, 8'h00);
    chk("term_done", s_done, 8'h01);
    nEOP = 1'b1; nDACK = 1'b1;
    cyc();
    chk("term_done_pulse", s_done, 8'h00);
    chk("term_busy", s_busy, 8'h00);

    // nEOP with DACK high belongs to another channel
    req_start = 1'b1; dir = 1'b0;
    cyc();
    req_start = 1'b0;
    nEOP = 1'b0;
    cyc();
    chk("eop_ign_busy", s_busy, 8'h01);
    chk("eop_ign_done", s_done, 8'h00);
    chk("eop_ign_dreq", s_dreq, 8'h01);
    nEOP = 1'b1;

    // Underflow on empty TX, with a stray req_start/dir change during ACK
    nDACK = 1'b0;
    cyc();
    req_start = 1'b1; dir = 1'b1; nIOR = 1'b0;
    #1;
    chk("unf_dout", s_dout, 8'h00);
    chk("unf_oe", s_oe, 8'h01);
    cyc();
    chk("unf_req_ignored", s_dbg, 8'h02);
    req_start = 1'b0; dir = 1'b0; nIOR = 1'b1;
    cyc();
    chk("unf_err", s_err, 8'h01);
    chk("unf_wait", s_dbg, 8'h03);
    nDACK = 1'b1;
    cyc();
    do_reset();

    // Demand mode, memory->device: 16 bytes streamed through RX
    rx_ready = 1'b1;
    req_start = 1'b1; dir = 1'b1;
    cyc();
    req_start = 1'b0;
    chk("dmd_dreq_req", d_dreq, 8'h01);
    nDACK = 1'b0;
    cyc();
    chk("dmd_dreq_ack", d_dreq, 8'h01);
    nIOR = 1'b0;
    #1;
    chk("dmd_wrong_dir_oe", d_oe, 8'h00);
    cyc();
    nIOR = 1'b1;
    cyc();
    chk("dmd_wrong_dir_rx", d_rx_valid, 8'h00);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      iow_byte(8'(i));
      chk("dmd_rx_valid", d_rx_valid, 8'h01);
      chk("dmd_rx_data", d_rx_data, exp_q.pop_front());
      chk("dmd_dreq_held", d_dreq, 8'h01);
    end
    cyc();
    rx_ready = 1'b0;
    chk("dmd_drained", d_rx_valid, 8'h00);

    // RX fills at 8 entries; the 9th byte overflows
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'h80 + 8'(i));
      iow_byte(8'h80 + 8'(i));
      chk("ovf_dreq", d_dreq, (i < 7) ? 8'h01 : 8'h00);
    end
    chk("ovf_err", d_err, 8'h02);
    rx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("ovf_rx_valid", d_rx_valid, 8'h01);
      chk("ovf_rx_data", d_rx_data, exp_q.pop_front());
      cyc();
    end
    chk("ovf_ninth_lost", d_rx_valid, 8'h00);
    chk("ovf_dreq_back", d_dreq, 8'h01);

    nEOP = 1'b0;
    cyc();
    chk("dmd_term_done", d_done, 8'h01);
    chk("dmd_term_dreq", d_dreq, 8'h00);
    nEOP = 1'b1; nDACK = 1'b1;
    cyc();
    chk("dmd_term_idle", d_busy, 8'h00);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
